// File: rtl/mips_dbg_pkg.sv
// Shared debug-path types and constants for the MIPS32 memory dump engine.
// The trailer constant follows MIPS_MEM_DUMP_CHECKSUM_EN.
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_SEND = 3'd3,
    S_CSUM = 3'd4,
    S_FIN  = 3'd5
  } dump_state_t;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
  localparam bit HAS_TRAILER = 1'b1;
`else
  localparam bit HAS_TRAILER = 1'b0;
`endif

endpackage

// File: rtl/mips_mem_dump.sv
// Post-halt data-memory readback streamed over valid/ready.
// Optional checksum trailer enabled by defining MIPS_MEM_DUMP_CHECKSUM_EN.
module mips_mem_dump
  import mips_dbg_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          start,
  input  logic          auto_en,
  input  logic          halted,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   word_count,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy,
  output logic          done
);

  dump_state_t   state;
  logic [AW-1:0] addr;
  logic [AW:0]   remaining;
  logic          halted_q;
  logic          trigger;
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
  logic [DW-1:0] sum;
`endif

  // A coincident start and halt edge collapse into a single trigger.
  assign trigger = start | (auto_en & halted & ~halted_q);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      halted_q   <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      halted_q <= halted;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            addr      <= base_addr;
            remaining <= word_count;
            busy      <= 1'b1;
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
            sum       <= '0;
`endif
            if (word_count == '0) begin
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
              dout       <= '0;
              dout_valid <= 1'b1;
              dout_last  <= 1'b1;
              state      <= S_CSUM;
`else
              done       <= 1'b1;
              state      <= S_FIN;
`endif
            end else begin
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
              state     <= S_RD;
            end
          end
        end
        S_RD: begin
          mem_rd_en <= 1'b0;
          state     <= S_WT;
        end
        S_WT: begin
          dout       <= mem_rdata;
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
          sum        <= sum + mem_rdata;
`endif
          remaining  <= remaining - (AW+1)'(1);
          addr       <= addr + AW'(1);
          dout_valid <= 1'b1;
          dout_last  <= !HAS_TRAILER && (remaining == (AW+1)'(1));
          state      <= S_SEND;
        end
        S_SEND: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            if (remaining != '0) begin
              mem_rd_en <= 1'b1;
              mem_addr  <= addr;
              state     <= S_RD;
            end else begin
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
              dout       <= sum;
              dout_valid <= 1'b1;
              dout_last  <= 1'b1;
              state      <= S_CSUM;
`else
              done       <= 1'b1;
              state      <= S_FIN;
`endif
            end
          end
        end
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            done       <= 1'b1;
            state      <= S_FIN;
          end
        end
`endif
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_dump.sv
// Directed bench for mips_mem_dump; trailer expectations follow MIPS_MEM_DUMP_CHECKSUM_EN.
module tb_mips_mem_dump;

`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        auto_en = 1'b0;
  logic        halted = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_last;
  logic        busy;
  logic        done;

  mips_mem_dump #(.AW(10), .DW(32)) dut (
    .clk1(clk1), .rst(rst), .start(start), .auto_en(auto_en), .halted(halted),
    .base_addr(base_addr), .word_count(word_count), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [0:1023];
  always @(posedge clk1) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  // Observers sample on the falling edge, between driven input changes and the next active edge.
  logic [32:0] rx[$];
  logic [9:0]  addr_log[$];
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          stable_err = 0;
  logic        prev_hold = 1'b0;
  logic [32:0] prev_word = '0;

  always @(negedge clk1) begin
    if (!rst) begin
      if (dout_valid && dout_ready) rx.push_back({dout_last, dout});
      if (mem_rd_en) begin
        rd_cnt <= rd_cnt + 1;
        addr_log.push_back(mem_addr);
      end
      if (done) done_cnt <= done_cnt + 1;
      if (prev_hold && (!dout_valid || {dout_last, dout} !== prev_word))
        stable_err <= stable_err + 1;
      prev_hold <= dout_valid && !dout_ready;
      prev_word <= {dout_last, dout};
    end else begin
      prev_hold <= 1'b0;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_start(input logic [9:0] b, input logic [10:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy; i++) tick();
    check({tag, "_timeout"}, busy, 0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 50 && !dout_valid; i++) tick();
    check({tag, "_valid_seen"}, dout_valid, 1);
  endtask

  int rb, db, ab, kb;

  initial begin
    mem[198] = 32'd5040;
    mem[199] = 32'd0;
    mem[200] = 32'd7;
    mem[1023] = 32'hAAAA_0001;
    mem[0]    = 32'h5555_0002;

    // Reset state
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_dout", dout, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Result window, ready high; also checks first-word latency
    rb = rx.size(); db = done_cnt; kb = rd_cnt;
    pulse_start(10'd198, 11'd3);
    check("rw_rd_en", mem_rd_en, 1);
    check("rw_addr", mem_addr, 198);
    check("rw_busy", busy, 1);
    tick();
    check("rw_wt_valid", dout_valid, 0);
    tick();
    check("rw_valid", dout_valid, 1);
    check("rw_first", dout, 5040);
    wait_idle("rw");
    check("rw_count", rx.size() - rb, 3 + CS);
    check("rw_w0", rx[rb + 0], {1'b0, 32'd5040});
    check("rw_w1", rx[rb + 1], {1'b0, 32'd0});
    check("rw_w2", rx[rb + 2], {~CS, 32'd7});
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
    check("rw_trailer", rx[rb + 3], {1'b1, 32'd5047});
`endif
    check("rw_done_once", done_cnt - db, 1);
    check("rw_reads", rd_cnt - kb, 3);

    // Backpressure: 5 stalled cycles in every SEND
    rb = rx.size(); db = done_cnt; kb = rd_cnt;
    dout_ready = 1'b0;
    pulse_start(10'd198, 11'd3);
    for (int k = 0; k < 3 + CS; k++) begin
      wait_valid("bp");
      repeat (5) tick();
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
    end
    dout_ready = 1'b1;
    wait_idle("bp");
    check("bp_count", rx.size() - rb, 3 + CS);
    check("bp_w0", rx[rb + 0], {1'b0, 32'd5040});
    check("bp_w1", rx[rb + 1], {1'b0, 32'd0});
    check("bp_w2", rx[rb + 2], {~CS, 32'd7});
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
    check("bp_trailer", rx[rb + 3], {1'b1, 32'd5047});
`endif
    check("bp_stable", stable_err, 0);
    check("bp_reads", rd_cnt - kb, 3);
    check("bp_done_once", done_cnt - db, 1);

    // Address wrap 1023 -> 0
    rb = rx.size(); ab = addr_log.size();
    pulse_start(10'd1023, 11'd2);
    wait_idle("wr");
    check("wr_reads", addr_log.size() - ab, 2);
    check("wr_addr0", addr_log[ab + 0], 1023);
    check("wr_addr1", addr_log[ab + 1], 0);
    check("wr_w0", rx[rb + 0], {1'b0, 32'hAAAA_0001});
    check("wr_w1", rx[rb + 1], {~CS, 32'h5555_0002});
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
    check("wr_trailer", rx[rb + 2], {1'b1, 32'hFFFF_0003});
`endif

    // Zero count
    rb = rx.size(); db = done_cnt; kb = rd_cnt;
    pulse_start(10'd5, 11'd0);
    check("zc_busy", busy, 1);
    check("zc_state_done", done, !CS);
    wait_idle("zc");
    check("zc_count", rx.size() - rb, CS);
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
    check("zc_trailer", rx[rb + 0], {1'b1, 32'd0});
`endif
    check("zc_done_once", done_cnt - db, 1);
    check("zc_no_reads", rd_cnt - kb, 0);

    // Auto trigger coincident with start, then halted held high
    rb = rx.size(); db = done_cnt;
    auto_en = 1'b1;
    halted  = 1'b1;
    pulse_start(10'd198, 11'd3);
    wait_idle("at");
    repeat (10) tick();
    check("at_idle", busy, 0);
    check("at_count", rx.size() - rb, 3 + CS);
    check("at_w2", rx[rb + 2], {~CS, 32'd7});
    check("at_done_once", done_cnt - db, 1);
    auto_en = 1'b0;
    halted  = 1'b0;
    tick();

    // Reset during SEND of the second word, then a fresh dump
    rb = rx.size(); db = done_cnt;
    dout_ready = 1'b0;
    pulse_start(10'd198, 11'd3);
    wait_valid("rm1");
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    wait_valid("rm2");
    check("rm_second", dout, 0);
    rst = 1'b1;
    #1;
    check("rm_valid", dout_valid, 0);
    check("rm_busy", busy, 0);
    tick();
    rst = 1'b0;
    dout_ready = 1'b1;
    repeat (3) tick();
    check("rm_no_done", done_cnt - db, 0);
    check("rm_count", rx.size() - rb, 1);
    rb = rx.size(); db = done_cnt;
    pulse_start(10'd200, 11'd1);
    wait_idle("rm_fresh");
    check("rm_fresh_count", rx.size() - rb, 1 + CS);
    check("rm_fresh_w0", rx[rb + 0], {~CS, 32'd7});
`ifdef MIPS_MEM_DUMP_CHECKSUM_EN
    check("rm_fresh_trailer", rx[rb + 1], {1'b1, 32'd7});
`endif
    check("rm_fresh_done", done_cnt - db, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mem_dump.md
# mips_mem_dump

Post-run memory readback engine for the pipelined MIPS32 core. It reads a contiguous window of data memory after the core halts, or on command, and streams the words out over a valid/ready interface. Benches and the debug link use it to collect results such as the factorial product without hierarchical peeks. It sits beside the core on a dedicated read port of the unified instruction/data memory, clocked from the core's phase-1 clock.

## Interface
Parameters:
- AW, 10: memory word-address width (1024 words).
- DW, 32: data word width.

Ports:
- clk1  in  1  clock; single clock domain, all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored unless idle.
- auto_en  in  1  when 1, a rising edge of halted also triggers a dump.
- halted  in  1  core HALTED flag.
- base_addr  in  AW  first word address; latched at trigger.
- word_count  in  AW+1  number of words, 0..2^AW; latched at trigger.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  AW  memory read address.
- mem_rdata  in  DW  read data, valid one cycle after mem_rd_en.
- dout  out  DW  streamed word.
- dout_valid  out  1  dout holds a word.
- dout_ready  in  1  sink accepts the word when high with dout_valid.
- dout_last  out  1  marks the final word of a dump.
- busy  out  1  high from the trigger until done.
- done  out  1  one-cycle pulse at the end of a dump.

## Operation
- States: IDLE, RD, WT, SEND, CSUM (CSUM exists only with the macro), FIN.
- Trigger = start | (auto_en & halted & ~halted_q), sampled in IDLE. halted_q is halted registered. A coincident start and halt edge produce one dump.
- On trigger: latch base_addr into addr and word_count into remaining, clear the sum. The next state is RD, or FIN if the count is 0 and the macro is off, or CSUM if the count is 0 and the macro is on.
- RD: mem_rd_en=1, mem_addr=addr. Go to WT.
- WT: capture mem_rdata into dout, add it to the sum, decrement remaining, increment addr modulo 2^AW (1023 wraps to 0). Go to SEND.
- SEND: dout_valid=1. dout and dout_last stay stable until the handshake. On dout_valid&dout_ready:
  - more words remain: go to RD;
  - otherwise: go to CSUM if the macro is on, else FIN.
- CSUM: dout = sum (DW bits, modulo 2^DW), dout_valid=1, dout_last=1. The handshake moves to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Reset values: state IDLE, all outputs 0, addr/remaining/sum 0, halted_q 0.
- An asynchronous reset mid-dump aborts it immediately: dout_valid and busy drop, no done pulse, no trailer.
- start pulses while busy are dropped, not queued.
- Memory read-data hazards are the caller's concern. Dumps are intended while the core is halted.

## Timing
- The trigger is sampled at edge 0. RD holds from edge 0 to edge 1. WT holds from edge 1 to edge 2. dout_valid rises after edge 2.
- With dout_ready held high, each word takes 3 cycles (RD, WT, SEND).
- busy is high from the cycle after edge 0 through the FIN cycle. done is high during FIN only.
- Zero-count dump with the macro off: FIN in the cycle after the trigger edge, no valid.

## Configuration
- MIPS_MEM_DUMP_CHECKSUM_EN defined:
  - a trailer word follows the data words;
  - the trailer is the modulo-2^32 sum of all emitted data words;
  - dout_last sits on the trailer only;
  - a zero-count dump emits a single trailer word of 0.
- MIPS_MEM_DUMP_CHECKSUM_EN undefined:
  - CSUM state and the sum register are absent;
  - dout_last sits on the final data word.

## Structure
- Shared package mips_dbg_pkg holds:
  - the state enum type;
  - default AW/DW constants;
  - the trailer-presence constant derived from the macro.
- Single module. No sub-module: the sum accumulator is one adder and is not worth a separate block.

## Test plan
- Result window: memory model holds Mem[198]=5040, Mem[199]=0, Mem[200]=7. Pulse start with base 198, count 3 and ready high. Expect 5040, 0, 7, and with the macro a trailer 5047 with last on it. Expect done once.
- Backpressure: the same dump with dout_ready low for 5 cycles in each SEND. dout must stay stable, no word may be duplicated or lost, and mem_rd_en may pulse only once per word.
- Wrap: base 1023, count 2. Expect mem_addr 1023 then 0.
- Zero count: macro off gives a done pulse with dout_valid never high. Macro on gives a single word 0 with last.
- Auto trigger: auto_en=1, halted rises 0→1 in the same cycle as start. Expect exactly one dump. halted staying high causes no retrigger.
- Reset mid-dump: assert rst while in SEND on the 2nd word. Expect dout_valid=0, busy=0 and no done. After release, a fresh start dumps normally from the new base.
